batch_reverse_buffer: RTL and testbench

BATCH_REVERSE_BUFFER -- requirements
Module: batch_reverse_buffer

---
 rtl/batch_reverse_buffer_if.sv | 22 ++
 rtl/batch_reverse_buffer.sv | 118 +++++++++++
 tb/tb_batch_reverse_buffer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/batch_reverse_buffer_if.sv
// Sample stream into the reverse buffer and the time-reversed stream out of it.
// The buffer owns the slave side; the producer/consumer owns the master side.
interface batch_reverse_buffer_if #(
  parameter int N = 3
);
  logic [N-1:0] in;
  logic         in_valid;
  logic [N-1:0] out;
  logic         out_valid;
  logic         out_first;
  logic         out_last;

  modport slave (
    input  in, in_valid,
    output out, out_valid, out_first, out_last
  );

  modport master (
    output in, in_valid,
    input  out, out_valid, out_first, out_last
  );
endinterface

// File: rtl/batch_reverse_buffer.sv
// Ping-pong batch buffer: collects `stages` samples in time order, then replays
// the completed batch newest-first while the other bank fills.
module batch_reverse_buffer #(
  parameter int stages = 32,
  parameter int N      = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  batch_reverse_buffer_if.slave   bus
);

  localparam int             CW       = (stages > 1) ? $clog2(stages) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(stages - 1);

  typedef enum logic {IDLE, READ} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic          wbank_q, wbank_d;
  logic          rbank_q, rbank_d;
  logic [N-1:0]  out_q, out_d;
  logic          out_valid_q, out_valid_d;
  logic          out_first_q, out_first_d;
  logic          out_last_q, out_last_d;

  logic [N-1:0]  mem_q [0:1][0:stages-1];

  logic wr_en;
  logic complete;

  assign wr_en    = bus.in_valid;
  assign complete = wr_en && (wcnt_q == CNT_LAST);

  // Storage is left uncleared by reset; the FSM only reads a bank after it fills.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wbank_q][wcnt_q] <= bus.in;
    end
  end

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    wbank_d     = wbank_q;
    rbank_d     = rbank_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    out_first_d = 1'b0;
    out_last_d  = 1'b0;

    if (wr_en) begin
      wcnt_d = complete ? '0 : wcnt_q + CW'(1);
      if (complete) begin
        wbank_d = ~wbank_q;
      end
    end

    case (state_q)
      IDLE: begin
        if (complete) begin
          state_d = READ;
          rcnt_d  = CNT_LAST;
          rbank_d = wbank_q;
        end
      end
      READ: begin
        out_d       = mem_q[rbank_q][rcnt_q];
        out_valid_d = 1'b1;
        out_first_d = (rcnt_q == CNT_LAST);
        out_last_d  = (rcnt_q == '0);
        if (rcnt_q == '0) begin
          // A batch finishing on the last read edge chains straight on, no gap.
          if (complete) begin
            rcnt_d  = CNT_LAST;
            rbank_d = wbank_q;
          end else begin
            state_d = IDLE;
          end
        end else begin
          rcnt_d = rcnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      wbank_q     <= wbank_d;
      rbank_q     <= rbank_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_first = out_first_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_batch_reverse_buffer.sv
// Directed bench: a stages=4/N=3 instance for hand-checked vectors and a
// stages=32/N=8 instance fed a gapped stream checked against a reversal queue.
module tb_batch_reverse_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  batch_reverse_buffer_if #(.N(3)) bus4 ();
  batch_reverse_buffer_if #(.N(8)) bus32 ();

  batch_reverse_buffer #(.stages(4), .N(3)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  batch_reverse_buffer #(.stages(32), .N(8)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // {valid, first, last, out}
  function automatic logic [5:0] obs4();
    return {bus4.out_valid, bus4.out_first, bus4.out_last, bus4.out};
  endfunction

  task automatic vec(input string tag, input logic v, input logic [2:0] d, input logic [5:0] e);
    bus4.in_valid = v;
    bus4.in       = d;
    @(posedge clk);
    #1;
    check(tag, obs4(), e);
  endtask

  task automatic do_reset(input string tag);
    bus4.in_valid  = 1'b0;
    bus4.in        = '0;
    bus32.in_valid = 1'b0;
    bus32.in       = '0;
    rst = 1'b0;
    #1;
    check({tag, "_async"}, obs4(), 6'b000000);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_state"}, obs4(), 6'b000000);
  endtask

  // Monitor for the 32-deep instance
  logic [7:0] exp_q[$];
  logic [7:0] bat[32];
  int  mon_pos = 0;
  int  nfirst  = 0;
  int  nlast   = 0;
  bit  mon_en  = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus32.out_first) nfirst++;
      if (bus32.out_last)  nlast++;
      if (bus32.out_valid) begin
        if (exp_q.size() == 0) begin
          check("t6_spurious", 32'(bus32.out_valid), 32'd0);
        end else begin
          check("t6_data", 32'(bus32.out), 32'(exp_q.pop_front()));
          check("t6_flags", 32'({bus32.out_first, bus32.out_last}),
                32'({mon_pos == 0, mon_pos == 31}));
        end
        mon_pos = (mon_pos == 31) ? 0 : mon_pos + 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    bit v;
    bus4.in_valid  = 1'b0;
    bus4.in        = '0;
    bus32.in_valid = 1'b0;
    bus32.in       = '0;
    #2;

    // Single batch, continuous input
    do_reset("t1_rst");
    vec("t1_in1",  1'b1, 3'd1, 6'b000000);
    vec("t1_in2",  1'b1, 3'd2, 6'b000000);
    vec("t1_in3",  1'b1, 3'd3, 6'b000000);
    vec("t1_in4",  1'b1, 3'd4, 6'b000000);
    vec("t1_out4", 1'b0, 3'd0, 6'b110100);
    vec("t1_out3", 1'b0, 3'd0, 6'b100011);
    vec("t1_out2", 1'b0, 3'd0, 6'b100010);
    vec("t1_out1", 1'b0, 3'd0, 6'b101001);
    vec("t1_idle", 1'b0, 3'd0, 6'b000001);
    vec("t1_hold", 1'b0, 3'd0, 6'b000001);

    // Two batches back to back: gapless chaining (8 wraps to 0 in 3 bits)
    do_reset("t2_rst");
    vec("t2_in1",  1'b1, 3'd1, 6'b000000);
    vec("t2_in2",  1'b1, 3'd2, 6'b000000);
    vec("t2_in3",  1'b1, 3'd3, 6'b000000);
    vec("t2_in4",  1'b1, 3'd4, 6'b000000);
    vec("t2_out4", 1'b1, 3'd5, 6'b110100);
    vec("t2_out3", 1'b1, 3'd6, 6'b100011);
    vec("t2_out2", 1'b1, 3'd7, 6'b100010);
    vec("t2_out1", 1'b1, 3'd0, 6'b101001);
    vec("t2_out8", 1'b0, 3'd0, 6'b110000);
    vec("t2_out7", 1'b0, 3'd0, 6'b100111);
    vec("t2_out6", 1'b0, 3'd0, 6'b100110);
    vec("t2_out5", 1'b0, 3'd0, 6'b101101);
    vec("t2_idle", 1'b0, 3'd0, 6'b000101);

    // Input gaps do not split the batch
    do_reset("t3_rst");
    vec("t3_in5",  1'b1, 3'd5, 6'b000000);
    vec("t3_in6",  1'b1, 3'd6, 6'b000000);
    vec("t3_gap1", 1'b0, 3'd7, 6'b000000);
    vec("t3_gap2", 1'b0, 3'd1, 6'b000000);
    vec("t3_gap3", 1'b0, 3'd2, 6'b000000);
    vec("t3_in7",  1'b1, 3'd7, 6'b000000);
    vec("t3_in0",  1'b1, 3'd0, 6'b000000);
    vec("t3_out0", 1'b0, 3'd0, 6'b110000);
    vec("t3_out7", 1'b0, 3'd0, 6'b100111);
    vec("t3_out6", 1'b0, 3'd0, 6'b100110);
    vec("t3_out5", 1'b0, 3'd0, 6'b101101);
    vec("t3_idle", 1'b0, 3'd0, 6'b000101);

    // Reset mid-batch discards the partial batch
    do_reset("t4_rst");
    vec("t4_in1",  1'b1, 3'd1, 6'b000000);
    vec("t4_in2",  1'b1, 3'd2, 6'b000000);
    bus4.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("t4_rst_async", obs4(), 6'b000000);
    @(posedge clk);
    #1;
    check("t4_rst_hold", obs4(), 6'b000000);
    rst = 1'b1;
    vec("t4_in3",  1'b1, 3'd3, 6'b000000);
    vec("t4_in5",  1'b1, 3'd5, 6'b000000);
    vec("t4_in6",  1'b1, 3'd6, 6'b000000);
    vec("t4_in2",  1'b1, 3'd2, 6'b000000);
    vec("t4_out2", 1'b0, 3'd0, 6'b110010);
    vec("t4_out6", 1'b0, 3'd0, 6'b100110);
    vec("t4_out5", 1'b0, 3'd0, 6'b100101);
    vec("t4_out3", 1'b0, 3'd0, 6'b101011);
    vec("t4_idle", 1'b0, 3'd0, 6'b000011);

    // Reset mid-read drops the rest of the batch
    do_reset("t5_rst");
    vec("t5_in1",  1'b1, 3'd1, 6'b000000);
    vec("t5_in2",  1'b1, 3'd2, 6'b000000);
    vec("t5_in3",  1'b1, 3'd3, 6'b000000);
    vec("t5_in4",  1'b1, 3'd4, 6'b000000);
    vec("t5_out4", 1'b0, 3'd0, 6'b110100);
    vec("t5_out3", 1'b0, 3'd0, 6'b100011);
    rst = 1'b0;
    #1;
    check("t5_rst_async", obs4(), 6'b000000);
    @(posedge clk);
    #1;
    check("t5_rst_hold", obs4(), 6'b000000);
    rst = 1'b1;
    vec("t5_after1", 1'b0, 3'd0, 6'b000000);
    vec("t5_after2", 1'b0, 3'd0, 6'b000000);
    vec("t5_after3", 1'b0, 3'd0, 6'b000000);

    // 32-deep instance: three batches with periodic input gaps
    do_reset("t6_rst");
    mon_pos = 0;
    nfirst  = 0;
    nlast   = 0;
    mon_en  = 1'b1;
    cnt = 0;
    for (int k = 0; k < 200 && cnt < 96; k++) begin
      v = ((k % 7) != 3);
      bus32.in_valid = v;
      bus32.in       = 8'(cnt * 37 + 11);
      @(posedge clk);
      #1;
      if (v) begin
        bat[cnt % 32] = 8'(cnt * 37 + 11);
        cnt++;
        if (cnt % 32 == 0) begin
          for (int j = 31; j >= 0; j--) exp_q.push_back(bat[j]);
        end
      end
    end
    bus32.in_valid = 1'b0;
    for (int w = 0; w < 80 && exp_q.size() != 0; w++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check("t6_drain",  32'(exp_q.size()), 32'd0);
    check("t6_nfirst", 32'(nfirst), 32'd3);
    check("t6_nlast",  32'(nlast), 32'd3);
    check("t6_idle",   32'(bus32.out_valid), 32'd0);
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
